// File: rtl/regfile_mp_pkg.sv
// Shared CPU definitions for the multi-port register file: sweep FSM encoding
// and the architectural indices of the syscall (v0) and stdout (a0) registers.
package regfile_mp_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int V0_IDX = 2;
  localparam int A0_IDX = 4;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: hardwired-zero entry 0, write-through bypass
// (write port 1 over port 0), and zeroed output while the clear sweep runs.
module regfile_rd_port #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic                    busy_i,
  input  logic [DEPTH*DATA_W-1:0] mem_i,
  input  logic                    we0_i,
  input  logic [ADDR_W-1:0]       wa0_i,
  input  logic [DATA_W-1:0]       wd0_i,
  input  logic                    we1_i,
  input  logic [ADDR_W-1:0]       wa1_i,
  input  logic [DATA_W-1:0]       wd1_i,
  output logic [DATA_W-1:0]       data_o
);

  always_comb begin
    data_o = '0;
    // A nonzero addr_i already excludes writes to entry 0 from the bypass.
    if (!busy_i && (addr_i != '0)) begin
      if (we1_i && (wa1_i == addr_i)) begin
        data_o = wd1_i;
      end else if (we0_i && (wa0_i == addr_i)) begin
        data_o = wd0_i;
      end else begin
        data_o = mem_i[int'(addr_i)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Register file with NUM_RD bypassed read ports, two write ports (load return wins)
// and a post-reset zeroing sweep, one entry per cycle, during which busy is high.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  parameter  int NUM_RD = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  output logic                     busy,
  output logic [DATA_W-1:0]        sys_call_reg,
  output logic [DATA_W-1:0]        std_out_address
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;

  logic clr_wr, wr0_ok, wr1_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        clr_cnt_d = '0;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy = (state_q == CLEAR);

  assign clr_wr = !rst && busy;
  assign wr0_ok = !rst && !busy && we0 && (wa0 != '0);
  assign wr1_ok = !rst && !busy && we1 && (wa1 != '0);

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      if (wr0_ok) mem_q[wa0] <= wd0;
      if (wr1_ok) mem_q[wa1] <= wd1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*DATA_W +: DATA_W] = mem_q[g];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd (
      .addr_i (rd_addr[p*ADDR_W +: ADDR_W]),
      .busy_i (busy),
      .mem_i  (mem_flat),
      .we0_i  (we0),
      .wa0_i  (wa0),
      .wd0_i  (wd0),
      .we1_i  (we1),
      .wa1_i  (wa1),
      .wd1_i  (wd1),
      .data_o (rd_data[p*DATA_W +: DATA_W])
    );
  end

  regfile_rd_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_v0_tap (
    .addr_i (ADDR_W'(V0_IDX)),
    .busy_i (busy),
    .mem_i  (mem_flat),
    .we0_i  (we0),
    .wa0_i  (wa0),
    .wd0_i  (wd0),
    .we1_i  (we1),
    .wa1_i  (wa1),
    .wd1_i  (wd1),
    .data_o (sys_call_reg)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_a0_tap (
    .addr_i (ADDR_W'(A0_IDX)),
    .busy_i (busy),
    .mem_i  (mem_flat),
    .we0_i  (we0),
    .wa0_i  (wa0),
    .wd0_i  (wd0),
    .we1_i  (we1),
    .wa1_i  (wa1),
    .wd1_i  (wd1),
    .data_o (std_out_address)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp (4 read ports) against an
// array-based reference model of the register file.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int DEP = 32;
  localparam int NR  = 4;
  localparam int AW  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic            we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0]   wa0 = '0, wa1 = '0;
  logic [DW-1:0]   wd0 = '0, wd1 = '0;
  logic            busy;
  logic [DW-1:0]   sys_call_reg, std_out_address;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem [DEP];
  int            run_cnt = 0;   // non-reset cycles since the last reset edge

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .DEPTH(DEP), .NUM_RD(NR)) dut (
    .clk             (clk),
    .rst             (rst),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .we0             (we0),
    .wa0             (wa0),
    .wd0             (wd0),
    .we1             (we1),
    .wa1             (wa1),
    .wd1             (wd1),
    .busy            (busy),
    .sys_call_reg    (sys_call_reg),
    .std_out_address (std_out_address)
  );

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (run_cnt < DEP || a == '0) return '0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return ref_mem[a];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check every output against the model, then advance one clock.
  task automatic tick();
    #1;
    for (int i = 0; i < NR; i++)
      chk($sformatf("rd%0d", i), rd_data[i*DW +: DW], exp_rd(rd_addr[i*AW +: AW]));
    chk("v0_tap", sys_call_reg, exp_rd(5'd2));
    chk("a0_tap", std_out_address, exp_rd(5'd4));
    chk("busy", {31'b0, busy}, (run_cnt < DEP) ? 32'd1 : 32'd0);
    @(posedge clk);
    if (rst) begin
      foreach (ref_mem[k]) ref_mem[k] = '0;
      run_cnt = 0;
    end else if (run_cnt < DEP) begin
      run_cnt++;
    end else begin
      if (we0 && wa0 != '0) ref_mem[wa0] = wd0;
      if (we1 && wa1 != '0) ref_mem[wa1] = wd1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  task automatic rand_inputs();
    we0 = 1'($urandom);
    we1 = 1'($urandom);
    wa0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    wa1 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    wd0 = $urandom;
    wd1 = $urandom;
    for (int i = 0; i < NR; i++)
      rd_addr[i*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
  endtask

  // Count cycles busy stays high; bounded so a stuck sweep still ends the run.
  task automatic busy_len(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy !== 1'b1) break;
      n++;
      tick();
    end
    chk(tag, DW'(n), 32'd32);
  endtask

  initial begin
    foreach (ref_mem[k]) ref_mem[k] = '0;
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);

    // Reset held 3 cycles; writes attempted during reset must be ignored.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
    end
    rst = 1'b0;
    rand_inputs();
    we0 = 1'b1; wa0 = 5'd3;
    we1 = 1'b1; wa1 = 5'd6;
    busy_len("busy_len_first");
    idle();
    rd_addr = {5'd6, 5'd3, 5'd1, 5'd31};
    tick();

    // Same-cycle bypass of port 0, then hold.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    rd_addr = {5'd9, 5'd9, 5'd9, 5'd5};
    #1 chk("bypass_wr0", rd_data[31:0], 32'hDEADBEEF);
    tick();
    idle();
    #1 chk("hold_5", rd_data[31:0], 32'hDEADBEEF);
    tick();

    // Collision: port 1 wins for bypass and storage.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    rd_addr = {4{5'd7}};
    #1 chk("prio_bypass", rd_data[31:0], 32'h22);
    tick();
    idle();
    #1 chk("prio_store", rd_data[63:32], 32'h22);
    tick();

    // Entry 0 is hardwired.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    rd_addr = {4{5'd0}};
    #1 chk("addr0_before", rd_data[31:0], 32'h0);
    tick();
    idle();
    #1 chk("addr0_after", rd_data[127:96], 32'h0);
    tick();

    // Taps, then a reset pulse partway through a sweep.
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h0A;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h1000;
    #1 chk("v0_bypass", sys_call_reg, 32'h0A);
    chk("a0_bypass", std_out_address, 32'h1000);
    tick();
    idle();
    #1 chk("v0_stored", sys_call_reg, 32'h0A);
    chk("a0_stored", std_out_address, 32'h1000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_len("busy_len_restart");
    #1 chk("v0_cleared", sys_call_reg, 32'h0);
    chk("a0_cleared", std_out_address, 32'h0);
    tick();

    // All four ports read the address being written by port 1.
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h55;
    rd_addr = {4{5'd9}};
    #1;
    for (int i = 0; i < NR; i++)
      chk($sformatf("quad_bypass%0d", i), rd_data[i*DW +: DW], 32'h55);
    tick();
    idle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
